core_reset_ctrl: RTL and testbench

Parametrised core reset sequencer for the CoCo2/Dragon top level. It merges N level reset requests (OSD reset, user button, ROM download, …) with a debounced machine-select configuration field into one registered `core_reset`. Configuration changes reach the core only while `core_reset` is high, and every release is a fixed-length, clean pulse. It replaces the ad-hoc machine-select reset counter and generalises it with source masking, a cause record and stability filtering.

---
 rtl/core_reset_ctrl.sv | 149 ++++++++++++++
 tb/tb_core_reset_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/core_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_reset_ctrl
// Brief    : Merges masked level reset requests and a debounced configuration
//            field into one registered core reset with a fixed-length release.
// Revision : 1.0 - initial release
// ============================================================================
module core_reset_ctrl #(
    parameter int NSRC   = 4,
    parameter int CFG_W  = 2,
    parameter int HOLD   = 15,
    parameter int STABLE = 4
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [NSRC-1:0]  req,
    input  logic [NSRC-1:0]  req_mask,
    input  logic [CFG_W-1:0] cfg_in,
    output logic             core_reset,
    output logic [CFG_W-1:0] cfg_out,
    output logic [NSRC:0]    cause,
    output logic             ready
);

    localparam int unsigned c_HCNT_W = $clog2(HOLD + 1);
    localparam int unsigned c_SCNT_W = $clog2(STABLE + 1);

    localparam logic [c_HCNT_W-1:0] c_HOLD_LOAD   = c_HCNT_W'(HOLD);
    localparam logic [c_HCNT_W-1:0] c_HCNT_LAST   = c_HCNT_W'(1);
    localparam logic [c_SCNT_W-1:0] c_SCNT_LAST   = c_SCNT_W'(STABLE - 1);
    localparam logic [c_SCNT_W-1:0] c_SCNT_ONE    = c_SCNT_W'(1);
    localparam logic [NSRC:0]       c_CAUSE_CFG   = {1'b1, {NSRC{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_ACTIVE  = 2'd2,
        S_HOLDING = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_HCNT_W-1:0] r_hcnt;
    logic [c_SCNT_W-1:0] r_scnt;
    logic [CFG_W-1:0]    r_last;
    logic [CFG_W-1:0]    r_cfg_out;
    logic [NSRC:0]       r_cause;
    logic                r_core_reset;
    logic                r_ready;

    logic [NSRC-1:0]     w_mreq;
    logic                w_any;
    logic                w_cfg_diff;

    assign w_mreq     = req & req_mask;
    assign w_any      = |w_mreq;
    assign w_cfg_diff = (cfg_in != r_cfg_out);

    // core_reset is registered alongside the state so it rises on the same
    // edge that applies a new cfg_out; cfg_out therefore never moves while low.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= S_HOLDING;
            r_hcnt       <= c_HOLD_LOAD;
            r_scnt       <= '0;
            r_last       <= cfg_in;
            r_cfg_out    <= cfg_in;
            r_cause      <= '0;
            r_core_reset <= 1'b1;
            r_ready      <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state      <= S_ACTIVE;
                        r_core_reset <= 1'b1;
                        r_cfg_out    <= cfg_in;
                        r_cause      <= {w_cfg_diff, w_mreq};
                    end else if (w_cfg_diff) begin
                        r_state <= S_PENDING;
                        r_last  <= cfg_in;
                        r_scnt  <= '0;
                    end
                end

                S_PENDING: begin
                    if (w_any) begin
                        r_state      <= S_ACTIVE;
                        r_core_reset <= 1'b1;
                        r_cfg_out    <= cfg_in;
                        r_cause      <= {1'b1, w_mreq};
                    end else if (cfg_in != r_last) begin
                        r_last <= cfg_in;
                        r_scnt <= '0;
                    end else if (!w_cfg_diff) begin
                        r_state <= S_IDLE;
                    end else if (r_scnt == c_SCNT_LAST) begin
                        r_state      <= S_HOLDING;
                        r_hcnt       <= c_HOLD_LOAD;
                        r_core_reset <= 1'b1;
                        r_cfg_out    <= cfg_in;
                        r_cause      <= c_CAUSE_CFG;
                    end else begin
                        r_scnt <= r_scnt + c_SCNT_ONE;
                    end
                end

                S_ACTIVE: begin
                    r_cfg_out <= cfg_in;
                    r_cause   <= r_cause | {w_cfg_diff, w_mreq};
                    if (!w_any) begin
                        r_state <= S_HOLDING;
                        r_hcnt  <= c_HOLD_LOAD;
                    end
                end

                S_HOLDING: begin
                    r_cfg_out <= cfg_in;
                    if (w_any) begin
                        r_state <= S_ACTIVE;
                        r_cause <= r_cause | {1'b0, w_mreq};
                    end else if (w_cfg_diff) begin
                        r_hcnt  <= c_HOLD_LOAD;
                        r_cause <= r_cause | c_CAUSE_CFG;
                    end else if (r_hcnt == c_HCNT_LAST) begin
                        r_state      <= S_IDLE;
                        r_core_reset <= 1'b0;
                        r_ready      <= 1'b1;
                    end else begin
                        r_hcnt <= r_hcnt - c_HCNT_LAST;
                    end
                end

                default: begin
                    r_state      <= S_HOLDING;
                    r_hcnt       <= c_HOLD_LOAD;
                    r_core_reset <= 1'b1;
                end
            endcase
        end
    end

    assign core_reset = r_core_reset;
    assign cfg_out    = r_cfg_out;
    assign cause      = r_cause;
    assign ready      = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_core_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_reset_ctrl
// Brief    : Directed cycle-by-cycle bench for core_reset_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_core_reset_ctrl;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] req_mask;
    logic [1:0] cfg_in;
    logic       core_reset;
    logic [1:0] cfg_out;
    logic [4:0] cause;
    logic       ready;

    always #5 clk_sys = ~clk_sys;

    core_reset_ctrl #(
        .NSRC   (4),
        .CFG_W  (2),
        .HOLD   (15),
        .STABLE (4)
    ) u_dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .req        (req),
        .req_mask   (req_mask),
        .cfg_in     (cfg_in),
        .core_reset (core_reset),
        .cfg_out    (cfg_out),
        .cause      (cause),
        .ready      (ready)
    );

    typedef struct {
        string      tag;
        logic       cr;
        logic       rdy;
        logic [1:0] cfg;
        logic [4:0] cs;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic cmp(input string tag, input string field,
                       input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    // Expected values are queued before each edge and retired after it.
    task automatic run(input int n, input logic cr, input logic rdy,
                       input logic [1:0] cfg, input logic [4:0] cs, input string tag);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.tag = tag; e.cr = cr; e.rdy = rdy; e.cfg = cfg; e.cs = cs;
            sb.push_back(e);
            @(posedge clk_sys);
            #1;
            e = sb.pop_front();
            cmp(e.tag, "core_reset", {7'd0, core_reset}, {7'd0, e.cr});
            cmp(e.tag, "ready",      {7'd0, ready},      {7'd0, e.rdy});
            cmp(e.tag, "cfg_out",    {6'd0, cfg_out},    {6'd0, e.cfg});
            cmp(e.tag, "cause",      {3'd0, cause},      {3'd0, e.cs});
        end
    endtask

    initial begin
        reset    = 1'b1;
        req      = 4'b0000;
        req_mask = 4'b1111;
        cfg_in   = 2'd2;

        // Power-on
        run(3,  1'b1, 1'b0, 2'd2, 5'b00000, "por_hold");
        reset = 1'b0;
        run(14, 1'b1, 1'b0, 2'd2, 5'b00000, "por_release");
        run(1,  1'b0, 1'b1, 2'd2, 5'b00000, "por_ready");
        run(2,  1'b0, 1'b0, 2'd2, 5'b00000, "por_idle");

        // Enabled request, then the same request masked off
        req = 4'b0100;
        run(5,  1'b1, 1'b0, 2'd2, 5'b00100, "req_active");
        req = 4'b0000;
        run(15, 1'b1, 1'b0, 2'd2, 5'b00100, "req_hold");
        run(1,  1'b0, 1'b1, 2'd2, 5'b00100, "req_ready");
        run(1,  1'b0, 1'b0, 2'd2, 5'b00100, "req_idle");
        req_mask = 4'b1011;
        req      = 4'b0100;
        run(5,  1'b0, 1'b0, 2'd2, 5'b00100, "masked");
        req      = 4'b0000;
        req_mask = 4'b1111;
        run(2,  1'b0, 1'b0, 2'd2, 5'b00100, "masked_idle");

        // Config changes 2->0, then 0->1
        cfg_in = 2'd0;
        run(4,  1'b0, 1'b0, 2'd2, 5'b00100, "cfg0_pending");
        run(15, 1'b1, 1'b0, 2'd0, 5'b10000, "cfg0_hold");
        run(1,  1'b0, 1'b1, 2'd0, 5'b10000, "cfg0_ready");
        run(1,  1'b0, 1'b0, 2'd0, 5'b10000, "cfg0_idle");
        cfg_in = 2'd1;
        run(4,  1'b0, 1'b0, 2'd0, 5'b10000, "cfg1_pending");
        run(15, 1'b1, 1'b0, 2'd1, 5'b10000, "cfg1_hold");
        run(1,  1'b0, 1'b1, 2'd1, 5'b10000, "cfg1_ready");
        run(1,  1'b0, 1'b0, 2'd1, 5'b10000, "cfg1_idle");

        // Reverted glitch: no episode, no ready
        cfg_in = 2'd2;
        run(2,  1'b0, 1'b0, 2'd1, 5'b10000, "glitch_up");
        cfg_in = 2'd1;
        run(4,  1'b0, 1'b0, 2'd1, 5'b10000, "glitch_back");

        // Changes every 3 cycles restart the window; settles on 2
        cfg_in = 2'd0;
        run(3,  1'b0, 1'b0, 2'd1, 5'b10000, "toggle_a");
        cfg_in = 2'd3;
        run(3,  1'b0, 1'b0, 2'd1, 5'b10000, "toggle_b");
        cfg_in = 2'd2;
        run(4,  1'b0, 1'b0, 2'd1, 5'b10000, "toggle_settle");
        run(15, 1'b1, 1'b0, 2'd2, 5'b10000, "toggle_hold");
        run(1,  1'b0, 1'b1, 2'd2, 5'b10000, "toggle_ready");
        run(1,  1'b0, 1'b0, 2'd2, 5'b10000, "toggle_idle");

        // Retrigger from HOLDING by request at hcnt=5, then by config at hcnt=3
        req = 4'b0010;
        run(2,  1'b1, 1'b0, 2'd2, 5'b00010, "rt_active");
        req = 4'b0000;
        run(11, 1'b1, 1'b0, 2'd2, 5'b00010, "rt_hold_a");
        req = 4'b0001;
        run(1,  1'b1, 1'b0, 2'd2, 5'b00011, "rt_req");
        req = 4'b0000;
        run(13, 1'b1, 1'b0, 2'd2, 5'b00011, "rt_hold_b");
        cfg_in = 2'd1;
        run(15, 1'b1, 1'b0, 2'd1, 5'b10011, "rt_cfg_hold");
        run(1,  1'b0, 1'b1, 2'd1, 5'b10011, "rt_ready");
        run(1,  1'b0, 1'b0, 2'd1, 5'b10011, "rt_idle");

        // Reset during PENDING
        cfg_in = 2'd0;
        run(2,  1'b0, 1'b0, 2'd1, 5'b10011, "rp_pending");
        reset = 1'b1;
        run(1,  1'b1, 1'b0, 2'd0, 5'b00000, "rp_reset");
        reset = 1'b0;
        run(14, 1'b1, 1'b0, 2'd0, 5'b00000, "rp_hold");
        run(1,  1'b0, 1'b1, 2'd0, 5'b00000, "rp_ready");
        run(1,  1'b0, 1'b0, 2'd0, 5'b00000, "rp_idle");

        // Reset during ACTIVE
        req = 4'b1000;
        run(2,  1'b1, 1'b0, 2'd0, 5'b01000, "ra_active");
        reset = 1'b1;
        req   = 4'b0000;
        run(1,  1'b1, 1'b0, 2'd0, 5'b00000, "ra_reset");
        reset = 1'b0;
        run(14, 1'b1, 1'b0, 2'd0, 5'b00000, "ra_hold");
        run(1,  1'b0, 1'b1, 2'd0, 5'b00000, "ra_ready");
        run(1,  1'b0, 1'b0, 2'd0, 5'b00000, "ra_idle");

        // Request and config change together from IDLE
        req    = 4'b0001;
        cfg_in = 2'd3;
        run(1,  1'b1, 1'b0, 2'd3, 5'b10001, "both_active");
        req = 4'b0000;
        run(15, 1'b1, 1'b0, 2'd3, 5'b10001, "both_hold");
        run(1,  1'b0, 1'b1, 2'd3, 5'b10001, "both_ready");
        run(1,  1'b0, 1'b0, 2'd3, 5'b10001, "both_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
